// File: rtl/uart_avmm_bridge.sv
// uart_avmm_bridge
//   Binary-packet UART (8N1) to Avalon-MM master bridge. Commands (MSB first):
//     0x57 addr[ADDR_BYTES] data[DATA_BYTES] -> single write, reply 0x06
//     0x52 addr[ADDR_BYTES]                  -> single read,  reply readdata
//     anything else while idle               -> reply 0x15
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   uart_rxd / uart_txd   serial in (asynchronous) / serial out, idle high
//   uart_cts / uart_rts   host ready to receive / bridge ready to receive
//   avm_*                 Avalon-MM master (byteenable always all ones)
//   busy                  parser is outside IDLE
module uart_avmm_bridge #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int UART_BAUDRATE  = 115200,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int USE_FLOWCTRL   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rxd,
  output logic                    uart_txd,
  input  logic                    uart_cts,
  output logic                    uart_rts,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_waitrequest,
  output logic                    busy
);
  localparam int BITDIV     = CLOCK_FREQ / UART_BAUDRATE;
  localparam int HALFDIV    = BITDIV / 2;
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int CW         = $clog2(BITDIV + 1);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_WDATA, P_BUSWR, P_BUSRD, P_RESP} p_state_t;

  // ---------------- RX ----------------
  rx_state_t     rx_state, rx_state_next;
  logic [2:0]    rxd_sync;  // [0],[1]: synchroniser, [2]: previous synchronised sample
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_stop_tick, rx_done, rx_ferr;

  assign rx_stop_tick = (rx_state == RX_STOP) && (rx_cnt == CW'(BITDIV - 1));
  assign rx_done      = rx_stop_tick && rxd_sync[1];
  assign rx_ferr      = rx_stop_tick && !rxd_sync[1];

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxd_sync[2] && !rxd_sync[1]) rx_state_next = RX_START;
      // Start bit re-checked mid-bit; a high level here is a glitch.
      RX_START: if (rx_cnt == CW'(HALFDIV - 1)) rx_state_next = rxd_sync[1] ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == CW'(BITDIV - 1) && rx_bit == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_cnt == CW'(BITDIV - 1)) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rxd_sync <= 3'b111;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_next;
      rxd_sync <= {rxd_sync[1:0], uart_rxd};
      if (rx_state != rx_state_next || (rx_state != RX_START && rx_cnt == CW'(BITDIV - 1)))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_DATA && rx_cnt == CW'(BITDIV - 1)) begin
        rx_shift <= {rxd_sync[1], rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- TX ----------------
  tx_state_t       tx_state, tx_state_next;
  logic [9:0]      tx_shift;  // idles all ones so bit 0 drives the line glitch-free
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [1:0]      cts_sync;
  logic            cts_ok, tx_start, resp_pop, nak_pop;
  logic [7:0]      tx_byte;
  logic [DATA_WIDTH-1:0] resp_buf;
  logic [2:0]      resp_left;
  logic [3:0]      nak_cnt;

  assign cts_ok   = (USE_FLOWCTRL == 0) || cts_sync[1];
  assign tx_start = (tx_state == TX_IDLE) && (resp_left != 3'd0 || nak_cnt != 4'd0) && cts_ok;
  assign resp_pop = tx_start && (resp_left != 3'd0);
  assign nak_pop  = tx_start && (resp_left == 3'd0);
  assign tx_byte  = (resp_left != 3'd0) ? resp_buf[DATA_WIDTH-1 -: 8] : NAK;
  assign uart_txd = tx_shift[0];

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_state_next = TX_SEND;
      TX_SEND: if (tx_cnt == CW'(BITDIV - 1) && tx_bit == 4'd9) tx_state_next = TX_IDLE;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      cts_sync <= '0;
    end else begin
      tx_state <= tx_state_next;
      cts_sync <= {cts_sync[0], uart_cts};
      if (tx_start) begin
        tx_shift <= {1'b1, tx_byte, 1'b0};
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state == TX_SEND) begin
        if (tx_cnt == CW'(BITDIV - 1)) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bit   <= tx_bit + 4'd1;
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
    end
  end

  // ---------------- Parser ----------------
  p_state_t              p_state, p_state_next;
  logic [2:0]            byte_cnt;
  logic                  is_wr;
  logic                  nak_push, to_expired;
  logic [31:0]           to_cnt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  assign to_expired = (TIMEOUT_CYCLES != 0) && (to_cnt >= 32'(TIMEOUT_CYCLES));

  always_comb begin
    p_state_next = p_state;
    nak_push     = 1'b0;
    case (p_state)
      P_IDLE:
        if (rx_done) begin
          if (rx_shift == CMD_WR || rx_shift == CMD_RD) p_state_next = P_ADDR;
          else                                          nak_push     = 1'b1;
        end
      P_ADDR:
        if (rx_ferr || to_expired)
          p_state_next = P_IDLE;
        else if (rx_done && byte_cnt == 3'(ADDR_BYTES - 1))
          p_state_next = is_wr ? P_WDATA : P_BUSRD;
      P_WDATA:
        if (rx_ferr || to_expired)
          p_state_next = P_IDLE;
        else if (rx_done && byte_cnt == 3'(DATA_BYTES - 1))
          p_state_next = P_BUSWR;
      P_BUSWR, P_BUSRD:
        if (!avm_waitrequest) p_state_next = P_RESP;
      P_RESP:
        if (resp_left == 3'd0 && tx_state == TX_IDLE) p_state_next = P_IDLE;
      default: p_state_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state   <= P_IDLE;
      byte_cnt  <= '0;
      is_wr     <= 1'b0;
      to_cnt    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      nak_cnt   <= '0;
    end else begin
      p_state <= p_state_next;
      if (p_state_next != p_state) byte_cnt <= '0;
      else if (rx_done)            byte_cnt <= byte_cnt + 3'd1;
      // Counts idle line time while a packet is half received.
      if (rx_state != RX_IDLE || !(p_state == P_ADDR || p_state == P_WDATA)) to_cnt <= '0;
      else if (!to_expired)                                                 to_cnt <= to_cnt + 32'd1;
      if (p_state == P_IDLE && rx_done) is_wr <= (rx_shift == CMD_WR);
      // Shifting into a register of the bus width drops surplus upper address bits.
      if (p_state == P_ADDR && rx_done)  addr_reg  <= ADDR_WIDTH'({addr_reg, rx_shift});
      if (p_state == P_WDATA && rx_done) wdata_reg <= DATA_WIDTH'({wdata_reg, rx_shift});
      if (p_state == P_BUSWR && !avm_waitrequest) begin
        resp_buf  <= DATA_WIDTH'(ACK) << (DATA_WIDTH - 8);
        resp_left <= 3'd1;
      end else if (p_state == P_BUSRD && !avm_waitrequest) begin
        resp_buf  <= avm_readdata;
        resp_left <= 3'(DATA_BYTES);
      end else if (resp_pop) begin
        resp_buf  <= resp_buf << 8;
        resp_left <= resp_left - 3'd1;
      end
      nak_cnt <= nak_cnt + 4'(nak_push && nak_cnt != 4'hF) - 4'(nak_pop);
    end
  end

  assign avm_address    = addr_reg;
  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = '1;
  assign avm_write      = (p_state == P_BUSWR);
  assign avm_read       = (p_state == P_BUSRD);
  assign busy           = (p_state != P_IDLE);
  assign uart_rts       = (USE_FLOWCTRL == 0) ||
                          !(p_state == P_BUSWR || p_state == P_BUSRD || p_state == P_RESP);
endmodule
